quiz_round_ctrl: RTL and testbench
==================================

Name: quiz_round_ctrl

Overview:
- Round sequencer for the speed mental-conversion quiz.
- Per round: latches a random 4-bit question, runs a tick-driven countdown, samples the player's 4-bit answer on submit, judges it and keeps score over a fixed number of rounds.
- Sits between the random source, debounced buttons/switches and the display path.
- Instantiates the digit splitter to drive tens/ones for the 7-segment display (countdown during play, final score at the end).

Parameters:
- ROUNDS, 10, rounds per game; legal range 1..15.
- TIME_LIMIT, 9, countdown start value in ticks; legal range 1..15.
- SHOW_TICKS, 2, ticks the result is held before the next round; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse, debounced; begins a game
- tick  in  1  single-cycle enable, nominally 1 Hz
- rand_val  in  4  free-running random value, sampled in LOAD
- answer  in  4  player switches, sampled on submit
- submit  in  1  single-cycle pulse, debounced
- question  out  4  current question value
- time_left  out  4  remaining ticks in current round
- score  out  4  correct answers this game
- round_idx  out  4  current round, 0-based
- busy  out  1  high in LOAD, ASK, JUDGE, SHOW
- result_valid  out  1  one-cycle pulse when a round is judged
- correct  out  1  result of last judged round; held until next judge
- game_done  out  1  high in DONE
- disp_tens  out  4  display tens digit
- disp_ones  out  4  display ones digit

Behaviour:
- Reset values: all registered outputs 0; state IDLE.
- States and transitions:
  - IDLE: start → LOAD; score := 0, round_idx := 0.
  - LOAD: one cycle. question := rand_val; time_left := TIME_LIMIT; → ASK.
  - ASK, submit: answer_q := answer; → JUDGE.
  - ASK, tick with time_left > 0: decrement time_left.
  - ASK, tick with time_left == 0: timeout; mark answer invalid; → JUDGE.
  - ASK, submit and timeout tick in the same cycle: submit wins.
  - JUDGE: one cycle. correct := valid && (answer_q == question); score += correct (saturate at 15); result_valid pulses this cycle; show_cnt := 0; → SHOW.
  - SHOW: on each tick show_cnt++; when show_cnt reaches SHOW_TICKS:
    - round_idx == ROUNDS-1 → DONE;
    - otherwise round_idx++ and → LOAD.
  - DONE: game_done = 1; start → LOAD with score := 0, round_idx := 0.
- start ignored in LOAD, ASK, JUDGE and SHOW.
- submit ignored outside ASK.
- tick ignored in IDLE, LOAD, JUDGE and DONE.
- Submit-to-result_valid latency: 2 cycles (ASK→JUDGE register, JUDGE pulse).
- Display source value:
  - ASK: time_left.
  - SHOW: question.
  - DONE: score.
  - Otherwise: 0.
- disp_tens/disp_ones are the combinational split (/10, %10) of the display source value; valid range 0..15.
- Asynchronous reset mid-game returns to IDLE immediately and clears all state.

Optional Feature:
- Macro QUIZ_NO_REPEAT_EN.
- Defined: LOAD stays in LOAD while rand_val equals the previous question (an internal prev register, cleared by reset and at game start so the first round never stalls). It advances on the first cycle where they differ. LOAD may then last several cycles. busy stays high throughout.
- Undefined: LOAD is always exactly one cycle; repeats are allowed.

Decomposition:
- Package quiz_pkg holds:
  - state enum: IDLE, LOAD, ASK, JUDGE, SHOW, DONE;
  - DIGIT_W = 4;
  - SCORE_MAX = 15.
- Sub-module: split_digits instantiated once for display conversion. No other sub-modules.

Test Plan:
- Reset mid-ASK (round 3, time_left 5) → next cycle all outputs 0, state IDLE, start then restarts at round 0.
- start; rand_val=11; submit with answer=11 → question=11, result_valid 2 cycles after submit, correct=1, score=1.
- ASK with TIME_LIMIT=9, no submit: 10 ticks → time_left 9..0 then timeout; correct=0, score unchanged; disp tens/ones track time_left (9→0,9).
- Submit and timeout tick in the same cycle with answer equal to question → judged correct.
- Full game, ROUNDS=10, all correct → game_done=1, score=10, disp_tens=1, disp_ones=0; second start clears score to 0.
- QUIZ_NO_REPEAT_EN defined: rand_val held at the previous question for 5 cycles → LOAD persists 5 cycles; changing rand_val to 4 → question=4 the next cycle.

Source files
------------

// File: rtl/quiz_pkg.sv
// quiz_pkg: shared state encoding, widths and helpers for the quiz round sequencer.
package quiz_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] SCORE_MAX = 4'd15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ASK   = 3'd2,
    JUDGE = 3'd3,
    SHOW  = 3'd4,
    DONE  = 3'd5
  } quiz_state_e;

  // Increment that sticks at SCORE_MAX instead of wrapping.
  function automatic logic [DIGIT_W-1:0] sat_inc(input logic [DIGIT_W-1:0] v);
    if (v == SCORE_MAX) begin
      return v;
    end else begin
      return v + 4'd1;
    end
  endfunction

endpackage

// File: rtl/split_digits.sv
// split_digits: converts a 0..15 value into decimal tens/ones digits for the 7-segment path.
module split_digits
  import quiz_pkg::*;
(
  input  logic [DIGIT_W-1:0] value,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones
);

  // Inputs never exceed 15, so the tens digit is at most 1.
  always_comb begin
    tens = 4'd0;
    ones = value;
    if (value >= 4'd10) begin
      tens = 4'd1;
      ones = value - 4'd10;
    end else begin
      tens = 4'd0;
      ones = value;
    end
  end

endmodule

// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: per-round question latch, tick countdown, answer judging and scoring.
// Optional QUIZ_NO_REPEAT_EN: LOAD holds until rand_val differs from the previous question.
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int unsigned ROUNDS     = 10,
  parameter int unsigned TIME_LIMIT = 9,
  parameter int unsigned SHOW_TICKS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic [DIGIT_W-1:0] rand_val,
  input  logic [DIGIT_W-1:0] answer,
  input  logic               submit,
  output logic [DIGIT_W-1:0] question,
  output logic [DIGIT_W-1:0] time_left,
  output logic [DIGIT_W-1:0] score,
  output logic [DIGIT_W-1:0] round_idx,
  output logic               busy,
  output logic               result_valid,
  output logic               correct,
  output logic               game_done,
  output logic [DIGIT_W-1:0] disp_tens,
  output logic [DIGIT_W-1:0] disp_ones
);

  localparam logic [DIGIT_W-1:0] LAST_ROUND = DIGIT_W'(ROUNDS - 1);
  localparam logic [DIGIT_W-1:0] TIME_INIT  = DIGIT_W'(TIME_LIMIT);
  localparam logic [DIGIT_W-1:0] SHOW_LAST  = DIGIT_W'(SHOW_TICKS - 1);

  quiz_state_e        state_r, state_nxt_s;
  logic [DIGIT_W-1:0] question_r, question_nxt_s;
  logic [DIGIT_W-1:0] time_left_r, time_left_nxt_s;
  logic [DIGIT_W-1:0] score_r, score_nxt_s;
  logic [DIGIT_W-1:0] round_idx_r, round_idx_nxt_s;
  logic [DIGIT_W-1:0] answer_q_r, answer_q_nxt_s;
  logic               ans_valid_r, ans_valid_nxt_s;
  logic               correct_r, correct_nxt_s;
  logic               result_valid_r, result_valid_nxt_s;
  logic [DIGIT_W-1:0] show_cnt_r, show_cnt_nxt_s;
  logic [DIGIT_W-1:0] disp_src_s;
`ifdef QUIZ_NO_REPEAT_EN
  logic               prev_vld_r, prev_vld_nxt_s;
  logic               load_stall_s;
  assign load_stall_s = prev_vld_r && (rand_val == question_r);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-datapath decode; every register holds unless its state acts on it.
  always_comb begin
    state_nxt_s        = state_r;
    question_nxt_s     = question_r;
    time_left_nxt_s    = time_left_r;
    score_nxt_s        = score_r;
    round_idx_nxt_s    = round_idx_r;
    answer_q_nxt_s     = answer_q_r;
    ans_valid_nxt_s    = ans_valid_r;
    correct_nxt_s      = correct_r;
    result_valid_nxt_s = 1'b0;
    show_cnt_nxt_s     = show_cnt_r;
`ifdef QUIZ_NO_REPEAT_EN
    prev_vld_nxt_s     = prev_vld_r;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt_s     = LOAD;
          score_nxt_s     = 4'd0;
          round_idx_nxt_s = 4'd0;
`ifdef QUIZ_NO_REPEAT_EN
          prev_vld_nxt_s  = 1'b0;
`endif
        end else begin
          state_nxt_s = state_r;
        end
      end
      LOAD: begin
`ifdef QUIZ_NO_REPEAT_EN
        if (load_stall_s) begin
          state_nxt_s = LOAD;
        end else begin
          question_nxt_s  = rand_val;
          time_left_nxt_s = TIME_INIT;
          prev_vld_nxt_s  = 1'b1;
          state_nxt_s     = ASK;
        end
`else
        question_nxt_s  = rand_val;
        time_left_nxt_s = TIME_INIT;
        state_nxt_s     = ASK;
`endif
      end
      ASK: begin
        // Submit takes priority over a coincident timeout tick.
        if (submit) begin
          answer_q_nxt_s  = answer;
          ans_valid_nxt_s = 1'b1;
          state_nxt_s     = JUDGE;
        end else if (tick) begin
          if (time_left_r != 4'd0) begin
            time_left_nxt_s = time_left_r - 4'd1;
          end else begin
            ans_valid_nxt_s = 1'b0;
            state_nxt_s     = JUDGE;
          end
        end else begin
          state_nxt_s = ASK;
        end
      end
      JUDGE: begin
        correct_nxt_s      = ans_valid_r && (answer_q_r == question_r);
        result_valid_nxt_s = 1'b1;
        show_cnt_nxt_s     = 4'd0;
        state_nxt_s        = SHOW;
        if (ans_valid_r && (answer_q_r == question_r)) begin
          score_nxt_s = sat_inc(score_r);
        end else begin
          score_nxt_s = score_r;
        end
      end
      SHOW: begin
        if (tick) begin
          if (show_cnt_r == SHOW_LAST) begin
            if (round_idx_r == LAST_ROUND) begin
              state_nxt_s = DONE;
            end else begin
              round_idx_nxt_s = round_idx_r + 4'd1;
              state_nxt_s     = LOAD;
            end
          end else begin
            show_cnt_nxt_s = show_cnt_r + 4'd1;
          end
        end else begin
          state_nxt_s = SHOW;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath registers, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      question_r     <= 4'd0;
      time_left_r    <= 4'd0;
      score_r        <= 4'd0;
      round_idx_r    <= 4'd0;
      answer_q_r     <= 4'd0;
      ans_valid_r    <= 1'b0;
      correct_r      <= 1'b0;
      result_valid_r <= 1'b0;
      show_cnt_r     <= 4'd0;
`ifdef QUIZ_NO_REPEAT_EN
      prev_vld_r     <= 1'b0;
`endif
    end else begin
      question_r     <= question_nxt_s;
      time_left_r    <= time_left_nxt_s;
      score_r        <= score_nxt_s;
      round_idx_r    <= round_idx_nxt_s;
      answer_q_r     <= answer_q_nxt_s;
      ans_valid_r    <= ans_valid_nxt_s;
      correct_r      <= correct_nxt_s;
      result_valid_r <= result_valid_nxt_s;
      show_cnt_r     <= show_cnt_nxt_s;
`ifdef QUIZ_NO_REPEAT_EN
      prev_vld_r     <= prev_vld_nxt_s;
`endif
    end
  end

  // Display source selection: countdown while asking, question while showing, score at the end.
  always_comb begin
    disp_src_s = 4'd0;
    case (state_r)
      ASK:     disp_src_s = time_left_r;
      SHOW:    disp_src_s = question_r;
      DONE:    disp_src_s = score_r;
      default: disp_src_s = 4'd0;
    endcase
  end

  split_digits u_split_digits (
    .value (disp_src_s),
    .tens  (disp_tens),
    .ones  (disp_ones)
  );

  assign question     = question_r;
  assign time_left    = time_left_r;
  assign score        = score_r;
  assign round_idx    = round_idx_r;
  assign correct      = correct_r;
  assign result_valid = result_valid_r;
  assign busy         = (state_r == LOAD) || (state_r == ASK) ||
                        (state_r == JUDGE) || (state_r == SHOW);
  assign game_done    = (state_r == DONE);

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb_quiz_round_ctrl: directed plus randomized stimulus checked every cycle against a behavioural game model.
module tb_quiz_round_ctrl;

  localparam int ROUNDS     = 10;
  localparam int TIME_LIMIT = 9;
  localparam int SHOW_TICKS = 2;

  logic       clk, rst, start, tick, submit;
  logic [3:0] rand_val, answer;
  logic [3:0] question, time_left, score, round_idx, disp_tens, disp_ones;
  logic       busy, result_valid, correct, game_done;

  int n_checks = 0;
  int n_fail   = 0;

  quiz_round_ctrl #(.ROUNDS(ROUNDS), .TIME_LIMIT(TIME_LIMIT), .SHOW_TICKS(SHOW_TICKS)) dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .rand_val(rand_val),
    .answer(answer), .submit(submit), .question(question), .time_left(time_left),
    .score(score), .round_idx(round_idx), .busy(busy), .result_valid(result_valid),
    .correct(correct), .game_done(game_done), .disp_tens(disp_tens), .disp_ones(disp_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the game in plain terms: which phase, what is on screen, what the player has earned.
  localparam int P_IDLE = 0, P_LOAD = 1, P_ASK = 2, P_JUDGE = 3, P_SHOW = 4, P_DONE = 5;
  int m_phase, m_q, m_t, m_score, m_round, m_ans, m_shown;
  bit m_ok, m_correct, m_rv, m_prev_vld;

  task automatic model_reset();
    m_phase = P_IDLE; m_q = 0; m_t = 0; m_score = 0; m_round = 0; m_ans = 0;
    m_shown = 0; m_ok = 0; m_correct = 0; m_rv = 0; m_prev_vld = 0;
  endtask

  task automatic model_step();
    bit stall;
    m_rv = 0;
    case (m_phase)
      P_IDLE, P_DONE: if (start) begin
        m_phase = P_LOAD; m_score = 0; m_round = 0; m_prev_vld = 0;
      end
      P_LOAD: begin
        stall = 0;
`ifdef QUIZ_NO_REPEAT_EN
        stall = m_prev_vld && (int'(rand_val) == m_q);
`endif
        if (!stall) begin
          m_q = rand_val; m_t = TIME_LIMIT; m_prev_vld = 1; m_phase = P_ASK;
        end
      end
      P_ASK: begin
        if (submit) begin
          m_ans = answer; m_ok = 1; m_phase = P_JUDGE;
        end else if (tick) begin
          if (m_t > 0) m_t = m_t - 1;
          else begin m_ok = 0; m_phase = P_JUDGE; end
        end
      end
      P_JUDGE: begin
        m_correct = m_ok && (m_ans == m_q);
        if (m_correct && m_score < 15) m_score = m_score + 1;
        m_rv = 1; m_shown = 0; m_phase = P_SHOW;
      end
      P_SHOW: if (tick) begin
        m_shown = m_shown + 1;
        if (m_shown == SHOW_TICKS) begin
          if (m_round == ROUNDS - 1) m_phase = P_DONE;
          else begin m_round = m_round + 1; m_phase = P_LOAD; end
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  always @(posedge clk) if (!rst) model_step();

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int v;
    v = (m_phase == P_ASK) ? m_t : (m_phase == P_SHOW) ? m_q : (m_phase == P_DONE) ? m_score : 0;
    check("question", 8'(question), 8'(m_q));
    check("time_left", 8'(time_left), 8'(m_t));
    check("score", 8'(score), 8'(m_score));
    check("round_idx", 8'(round_idx), 8'(m_round));
    check("busy", 8'(busy), 8'(m_phase >= P_LOAD && m_phase <= P_SHOW));
    check("result_valid", 8'(result_valid), 8'(m_rv));
    check("correct", 8'(correct), 8'(m_correct));
    check("game_done", 8'(game_done), 8'(m_phase == P_DONE));
    check("disp_tens", 8'(disp_tens), 8'(v / 10));
    check("disp_ones", 8'(disp_ones), 8'(v % 10));
  end

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask
  task automatic pulse_tick();
    tick = 1'b1; @(negedge clk); tick = 1'b0;
  endtask
  task automatic pulse_submit(input logic [3:0] a);
    answer = a; submit = 1'b1; @(negedge clk); submit = 1'b0;
  endtask

  initial begin
    int r, q_prev;
    rst = 1'b1; start = 1'b0; tick = 1'b0; submit = 1'b0; rand_val = 4'd0; answer = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 8'(busy), 8'd0);
    check("reset_score", 8'(score), 8'd0);

    // Basic correct answer.
    rand_val = 4'd11;
    pulse_start();
    @(negedge clk);
    check("lit_question", 8'(question), 8'd11);
    check("lit_time_init", 8'(time_left), 8'd9);
    check("lit_disp_ones_ask", 8'(disp_ones), 8'd9);
    pulse_submit(4'd11);
    check("lit_rv_early", 8'(result_valid), 8'd0);
    @(negedge clk);
    check("lit_rv", 8'(result_valid), 8'd1);
    check("lit_correct", 8'(correct), 8'd1);
    check("lit_score1", 8'(score), 8'd1);
    check("lit_show_tens", 8'(disp_tens), 8'd1);
    check("lit_show_ones", 8'(disp_ones), 8'd1);

    // Timeout round.
    rand_val = 4'd7;
    pulse_tick(); pulse_tick();
    check("lit_round1", 8'(round_idx), 8'd1);
    @(negedge clk);
    for (int i = 1; i <= 9; i++) begin
      pulse_tick();
      check("lit_countdown", 8'(time_left), 8'(9 - i));
      check("lit_cd_ones", 8'(disp_ones), 8'(9 - i));
      check("lit_cd_tens", 8'(disp_tens), 8'd0);
    end
    pulse_tick();
    @(negedge clk);
    check("lit_to_rv", 8'(result_valid), 8'd1);
    check("lit_to_correct", 8'(correct), 8'd0);
    check("lit_to_score", 8'(score), 8'd1);

    // Submit and timeout tick together: submit wins.
    rand_val = 4'd5;
    pulse_tick(); pulse_tick();
    @(negedge clk);
    repeat (9) pulse_tick();
    answer = 4'd5; submit = 1'b1; tick = 1'b1;
    @(negedge clk);
    submit = 1'b0; tick = 1'b0;
    @(negedge clk);
    check("lit_race_correct", 8'(correct), 8'd1);
    check("lit_race_score", 8'(score), 8'd2);

    // Asynchronous reset mid-ASK in round 3.
    rand_val = 4'd12;
    pulse_tick(); pulse_tick();
    @(negedge clk);
    repeat (4) pulse_tick();
    check("lit_pre_rst_round", 8'(round_idx), 8'd3);
    check("lit_pre_rst_time", 8'(time_left), 8'd5);
    #2 rst = 1'b1; model_reset();
    #1;
    check("lit_rst_time", 8'(time_left), 8'd0);
    check("lit_rst_round", 8'(round_idx), 8'd0);
    check("lit_rst_busy", 8'(busy), 8'd0);
    check("lit_rst_question", 8'(question), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    q_prev = 0;
    rand_val = 4'd3;
    pulse_start();
    check("lit_restart_busy", 8'(busy), 8'd1);

    // Full game, every answer right.
    for (int k = 0; k < ROUNDS; k++) begin
      r = (q_prev + 1 + int'($urandom_range(0, 14))) % 16;
      rand_val = 4'(r);
      q_prev = r;
      @(negedge clk);
      pulse_submit(4'(r));
      @(negedge clk);
      pulse_tick(); pulse_tick();
    end
    check("lit_done", 8'(game_done), 8'd1);
    check("lit_final_score", 8'(score), 8'd10);
    check("lit_final_tens", 8'(disp_tens), 8'd1);
    check("lit_final_ones", 8'(disp_ones), 8'd0);
    rand_val = 4'd9;
    pulse_start();
    check("lit_clear_score", 8'(score), 8'd0);
    check("lit_clear_done", 8'(game_done), 8'd0);

`ifdef QUIZ_NO_REPEAT_EN
    @(negedge clk);
    pulse_submit(4'd9);
    @(negedge clk);
    pulse_tick(); pulse_tick();
    repeat (5) begin
      @(negedge clk);
      check("lit_stall_q", 8'(question), 8'd9);
      check("lit_stall_disp", 8'(disp_ones), 8'd0);
      check("lit_stall_busy", 8'(busy), 8'd1);
    end
    rand_val = 4'd4;
    @(negedge clk);
    check("lit_unstall_q", 8'(question), 8'd4);
`endif

    // Randomized play.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1; model_reset();
        @(negedge clk);
        rst = 1'b0;
      end else begin
        start    = ($urandom_range(0, 39) == 0);
        tick     = ($urandom_range(0, 2) == 0);
        submit   = ($urandom_range(0, 7) == 0);
        rand_val = 4'($urandom_range(0, 15));
        answer   = $urandom_range(0, 1) ? 4'(m_q) : 4'($urandom_range(0, 15));
        @(negedge clk);
      end
    end
    start = 1'b0; tick = 1'b0; submit = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
